alu_share_arbiter: RTL and testbench

- Shares one 4-bit adder/subtractor datapath between two requesters (port 0, port 1).
- Uses round-robin arbitration with valid/ready request and response handshakes.
- Registers the result and holds it until the owning requester accepts it.
- Sits between the two ALU clients and the single adder_subtractor instance it contains.

---
 rtl/alu_share_arbiter.sv | 93 +++++++++
 tb/tb_alu_share_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one 4-bit adder/subtractor through a
// round-robin (or fixed-priority) grant and a registered, held response.
module adder_subtractor (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       sub,
   output logic [3:0] sum,
   output logic       carry
);
   // Subtraction as A + ~B + 1, so carry=1 means no borrow.
   assign {carry, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {4'b0, sub};
endmodule

module alu_share_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req0_sub,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic       req1_sub,
   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [3:0] rsp_out,
   output logic       rsp_carry,
   output logic       rsp_zero,
   output logic       busy
);
   typedef enum logic {IDLE, RESP} state_t;
   state_t     state;
   logic       last_grant;
   logic       owner;
   logic       grant;
   logic       any_valid;
   logic       accept;
   logic       done;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       op_sub;
   logic [3:0] sum;
   logic       carry;
   always_comb begin
      any_valid  = req0_valid | req1_valid;
      grant      = (req0_valid & req1_valid) ? (RR_EN ? ~last_grant : 1'b0) : req1_valid;
      req0_ready = !rst && state == IDLE && any_valid && !grant;
      req1_ready = !rst && state == IDLE && any_valid && grant;
      accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
      op_a       = grant ? req1_a : req0_a;
      op_b       = grant ? req1_b : req0_b;
      op_sub     = grant ? req1_sub : req0_sub;
      rsp0_valid = state == RESP && !owner;
      rsp1_valid = state == RESP && owner;
      done       = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
      busy       = state == RESP;
   end
   adder_subtractor u_alu (
      .a     (op_a),
      .b     (op_b),
      .sub   (op_sub),
      .sum   (sum),
      .carry (carry)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         rsp_out    <= 4'd0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            state      <= RESP;
            last_grant <= grant;
            owner      <= grant;
            rsp_out    <= sum;
            rsp_carry  <= carry;
            rsp_zero   <= sum == 4'd0;
         end
      end else if (done) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arithmetic, arbitration, backpressure
// and reset, with a round-robin and a fixed-priority instance on shared inputs.
module tb_alu_share_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic       req0_sub = 1'b0, req1_sub = 1'b0;
   logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic       r_req0_ready, r_req1_ready, r_rsp0_valid, r_rsp1_valid, r_carry, r_zero, r_busy;
   logic [3:0] r_out;
   logic       f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_carry, f_zero, f_busy;
   logic [3:0] f_out;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .rsp0_valid(r_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(r_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_out(r_out), .rsp_carry(r_carry), .rsp_zero(r_zero), .busy(r_busy)
   );

   alu_share_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_out(f_out), .rsp_carry(f_carry), .rsp_zero(f_zero), .busy(f_busy)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One uncontended operation on a port, with the response consumed at once.
   task automatic do_op(input logic port, input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic [3:0] exp_out, input logic exp_carry);
      if (port) begin
         req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
      end
      #1;
      chk("op_req_ready", port ? r_req1_ready : r_req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("op_rsp_valid", {r_rsp1_valid, r_rsp0_valid}, port ? 2'b10 : 2'b01);
      chk("op_out", r_out, exp_out);
      chk("op_carry", r_carry, exp_carry);
      chk("op_zero", r_zero, exp_out == 4'd0);
      chk("op_busy", r_busy, 1'b1);
      step();
      chk("op_idle", {r_busy, r_rsp1_valid, r_rsp0_valid}, 3'b000);
   endtask

   initial begin
      // Reset, with a request pending to confirm ready is held low.
      req0_valid = 1'b1;
      step();
      step();
      chk("rst_ready", {r_req1_ready, r_req0_ready, f_req1_ready, f_req0_ready}, 4'b0000);
      chk("rst_rsp_valid", {r_rsp1_valid, r_rsp0_valid}, 2'b00);
      chk("rst_out", {r_out, r_carry, r_zero, r_busy}, 7'd0);
      req0_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("idle_ready", {r_req1_ready, r_req0_ready}, 2'b00);

      // Arithmetic on each port.
      do_op(1'b0, 4'd5, 4'd3, 1'b0, 4'd8, 1'b0);
      do_op(1'b1, 4'd3, 4'd5, 1'b1, 4'b1110, 1'b0);
      do_op(1'b1, 4'd7, 4'd7, 1'b1, 4'd0, 1'b1);
      do_op(1'b1, 4'd9, 4'd8, 1'b0, 4'd1, 1'b1);

      // Continuous contention: last grant is port 1, so round-robin starts at 0.
      req0_a = 4'd1; req0_b = 4'd1; req0_sub = 1'b0;
      req1_a = 4'd2; req1_b = 4'd1; req1_sub = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_grant", {r_req1_ready, r_req0_ready}, (i % 2) ? 2'b10 : 2'b01);
         chk("fp_grant", {f_req1_ready, f_req0_ready}, 2'b01);
         step();
         chk("rr_owner", {r_rsp1_valid, r_rsp0_valid}, (i % 2) ? 2'b10 : 2'b01);
         chk("rr_out", r_out, (i % 2) ? 4'd1 : 4'd2);
         chk("rr_resp_ready", {r_req1_ready, r_req0_ready}, 2'b00);
         chk("fp_owner", {f_rsp1_valid, f_rsp0_valid}, 2'b01);
         chk("fp_out", f_out, 4'd2);
         step();
      end
      req0_valid = 1'b0;
      #1;
      chk("fp_p1_grant", {f_req1_ready, f_req0_ready}, 2'b10);
      step();
      chk("fp_p1_owner", {f_rsp1_valid, f_rsp0_valid}, 2'b10);
      chk("fp_p1_out", {f_out, f_carry}, {4'd1, 1'b1});
      req1_valid = 1'b0;
      step();

      // Backpressure on port 0 while port 1 waits.
      req0_a = 4'd5; req0_b = 4'd3; req0_sub = 1'b0;
      rsp0_ready = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("bp_grant", {r_req1_ready, r_req0_ready}, 2'b01);
      step();
      req0_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", {r_rsp1_valid, r_rsp0_valid}, 2'b01);
         chk("bp_hold_out", {r_out, r_carry}, {4'd8, 1'b0});
         chk("bp_p1_blocked", r_req1_ready, 1'b0);
         step();
      end
      rsp0_ready = 1'b1;
      #1;
      chk("bp_bubble", r_req1_ready, 1'b0);
      step();
      chk("bp_done", {r_busy, r_rsp0_valid, r_req1_ready}, 3'b001);
      step();
      chk("bp_p1_owner", {r_rsp1_valid, r_rsp0_valid}, 2'b10);
      chk("bp_p1_out", r_out, 4'd1);
      req1_valid = 1'b0;
      step();

      // Reset while a response is held; last grant then returns to port 1.
      rsp0_ready = 1'b0;
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      chk("rr_pre_rst", r_rsp0_valid, 1'b1);
      rst = 1'b1;
      step();
      chk("rr_post_rst", {r_rsp0_valid, r_busy, r_out}, 6'd0);
      rst = 1'b0;
      rsp0_ready = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rst_tie", {r_req1_ready, r_req0_ready}, 2'b01);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
